// File: rtl/ysyx_22040088_memarb.sv
// Fetch / load-store arbiter in front of a single-outstanding memory port.
// Responses are registered, so the owner's rsp_valid pulses the cycle after mem_rsp_valid or timeout.
module ysyx_22040088_memarb #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    input  logic [63:0] if_req_addr,
    output logic        if_req_ready,
    output logic        if_rsp_valid,
    output logic        if_rsp_err,
    output logic [63:0] if_rsp_data,
    input  logic        ls_req_valid,
    input  logic        ls_req_wen,
    input  logic [63:0] ls_req_addr,
    input  logic [63:0] ls_req_wdata,
    input  logic [7:0]  ls_req_wmask,
    output logic        ls_req_ready,
    output logic        ls_rsp_valid,
    output logic        ls_rsp_err,
    output logic [63:0] ls_rsp_data,
    output logic        mem_req_valid,
    output logic        mem_req_wen,
    output logic [63:0] mem_req_addr,
    output logic [63:0] mem_req_wdata,
    output logic [7:0]  mem_req_wmask,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [63:0] mem_rsp_data,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic        last_ls_reg, last_ls_next;
    logic        owner_ls_reg, owner_ls_next;
    logic        wen_reg, wen_next;
    logic [63:0] addr_reg, addr_next;
    logic [63:0] wdata_reg, wdata_next;
    logic [7:0]  wmask_reg, wmask_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic        grant_ls, grant_if;
    logic        rsp_fire, rsp_err;
    logic [63:0] rsp_data;

    // LS normally wins; IF takes the slot right after an LS grant when both are waiting.
    assign grant_ls = ls_req_valid && !(if_req_valid && last_ls_reg);
    assign grant_if = if_req_valid && !grant_ls;

    always_comb begin
        state_next    = state_reg;
        last_ls_next  = last_ls_reg;
        owner_ls_next = owner_ls_reg;
        wen_next      = wen_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        wmask_next    = wmask_reg;
        cnt_next      = cnt_reg;
        if_req_ready  = 1'b0;
        ls_req_ready  = 1'b0;
        mem_req_valid = 1'b0;
        rsp_fire      = 1'b0;
        rsp_err       = 1'b0;
        rsp_data      = 64'h0;
        case (state_reg)
            IDLE: begin
                if_req_ready = grant_if;
                ls_req_ready = grant_ls;
                if (grant_ls) begin
                    state_next    = REQ;
                    last_ls_next  = 1'b1;
                    owner_ls_next = 1'b1;
                    wen_next      = ls_req_wen;
                    addr_next     = ls_req_addr;
                    wdata_next    = ls_req_wdata;
                    wmask_next    = ls_req_wmask;
                end else if (grant_if) begin
                    state_next    = REQ;
                    last_ls_next  = 1'b0;
                    owner_ls_next = 1'b0;
                    wen_next      = 1'b0;
                    addr_next     = if_req_addr;
                    wdata_next    = 64'h0;
                    wmask_next    = 8'h0;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_next = RESP;
                    cnt_next   = 8'd0;
                end
            end
            RESP: begin
                // A response arriving on the last allowed cycle still beats the timeout.
                if (mem_rsp_valid) begin
                    rsp_fire   = 1'b1;
                    rsp_data   = wen_reg ? 64'h0 : mem_rsp_data;
                    state_next = IDLE;
                end else if (cnt_reg == TMO_LAST) begin
                    rsp_fire   = 1'b1;
                    rsp_err    = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            last_ls_reg  <= 1'b0;
            owner_ls_reg <= 1'b0;
            wen_reg      <= 1'b0;
            addr_reg     <= 64'h0;
            wdata_reg    <= 64'h0;
            wmask_reg    <= 8'h0;
            cnt_reg      <= 8'd0;
        end else begin
            state_reg    <= state_next;
            last_ls_reg  <= last_ls_next;
            owner_ls_reg <= owner_ls_next;
            wen_reg      <= wen_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            wmask_reg    <= wmask_next;
            cnt_reg      <= cnt_next;
        end
    end

    // Port 0 is fetch, port 1 is load-store; data/err hold between pulses.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        localparam logic IS_LS = (gi == 1);
        logic        valid_reg;
        logic        err_reg;
        logic [63:0] data_reg;

        always_ff @(posedge clk) begin
            if (!rst) begin
                valid_reg <= 1'b0;
                err_reg   <= 1'b0;
                data_reg  <= 64'h0;
            end else begin
                valid_reg <= rsp_fire && (owner_ls_reg == IS_LS);
                if (rsp_fire && (owner_ls_reg == IS_LS)) begin
                    err_reg  <= rsp_err;
                    data_reg <= rsp_data;
                end
            end
        end
    end

    assign if_rsp_valid  = g_port[0].valid_reg;
    assign if_rsp_err    = g_port[0].err_reg;
    assign if_rsp_data   = g_port[0].data_reg;
    assign ls_rsp_valid  = g_port[1].valid_reg;
    assign ls_rsp_err    = g_port[1].err_reg;
    assign ls_rsp_data   = g_port[1].data_reg;
    assign mem_req_wen   = wen_reg;
    assign mem_req_addr  = addr_reg;
    assign mem_req_wdata = wdata_reg;
    assign mem_req_wmask = wmask_reg;
    assign busy          = (state_reg != IDLE);
endmodule

// File: tb/tb_ysyx_22040088_memarb.sv
// Self-checking bench for the fetch/load-store memory arbiter: directed scenarios plus a
// randomized run checked against a transaction-level model of grants, latency and responses.
module tb_ysyx_22040088_memarb;
    localparam int TMO   = 16;
    localparam int WATCH = 40;

    logic        clk;
    logic        rst;
    logic        if_req_valid;
    logic [63:0] if_req_addr;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic        if_rsp_err;
    logic [63:0] if_rsp_data;
    logic        ls_req_valid;
    logic        ls_req_wen;
    logic [63:0] ls_req_addr;
    logic [63:0] ls_req_wdata;
    logic [7:0]  ls_req_wmask;
    logic        ls_req_ready;
    logic        ls_rsp_valid;
    logic        ls_rsp_err;
    logic [63:0] ls_rsp_data;
    logic        mem_req_valid;
    logic        mem_req_wen;
    logic [63:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_data;
    logic        busy;

    ysyx_22040088_memarb #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_err(if_rsp_err), .if_rsp_data(if_rsp_data),
        .ls_req_valid(ls_req_valid), .ls_req_wen(ls_req_wen), .ls_req_addr(ls_req_addr),
        .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask), .ls_req_ready(ls_req_ready),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_err(ls_rsp_err), .ls_rsp_data(ls_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    bit model_last_ls;

    bit          acc_if, acc_ls, obs_idle_mrv, obs_resp_mrv, obs_busy_req, obs_stable, obs_ready_busy;
    int          obs_req_cycles;
    logic        obs_wen;
    logic [63:0] obs_addr, obs_wdata;
    logic [7:0]  obs_wmask;
    int          pulse_lat;
    bit          pulse_if, pulse_ls;
    logic        pulse_err;
    logic [63:0] pulse_data;

    function automatic logic [63:0] rand_addr();
        logic [63:0] a;
        a = {$urandom, $urandom};
        return a & ~64'h7;
    endfunction

    // Arbitration rule: a lone requester wins; with both waiting LS wins unless it had the last grant.
    function automatic bit model_pick_ls(input bit if_v, input bit ls_v, input bit last_ls);
        if (!ls_v) return 1'b0;
        if (!if_v) return 1'b1;
        return !last_ls;
    endfunction

    function automatic void model_resp(input int rdy, input int dly, input bit sent, input bit wen,
                                       input logic [63:0] d, output int lat, output bit err,
                                       output logic [63:0] data);
        if (sent && dly < TMO) begin
            lat = 3 + rdy + dly; err = 1'b0; data = wen ? 64'h0 : d;
        end else begin
            lat = 2 + rdy + TMO; err = 1'b1; data = 64'h0;
        end
    endfunction

    // Plays the memory side for one transaction whose request is presented in the current cycle.
    // Returns in the cycle the response pulse is seen (or after WATCH cycles).
    task automatic serve(input int rdy_dly, input int rsp_dly, input bit send_rsp, input logic [63:0] data);
        int t0;
        #1;
        acc_if = if_req_ready; acc_ls = ls_req_ready; obs_idle_mrv = mem_req_valid; t0 = cyc;
        obs_ready_busy = 1'b0;
        @(negedge clk);
        if (acc_if) begin if_req_valid = 1'b0; if_req_addr = rand_addr(); end
        if (acc_ls) begin
            ls_req_valid = 1'b0; ls_req_addr = rand_addr(); ls_req_wdata = {$urandom, $urandom};
            ls_req_wmask = 8'($urandom); ls_req_wen = 1'($urandom);
        end
        mem_req_ready = (rdy_dly == 0);
        #1;
        obs_wen = mem_req_wen; obs_addr = mem_req_addr; obs_wdata = mem_req_wdata;
        obs_wmask = mem_req_wmask; obs_busy_req = busy; obs_stable = 1'b1; obs_req_cycles = 0;
        for (int i = 0; i <= rdy_dly; i++) begin
            if (i > 0) begin
                @(negedge clk);
                mem_req_ready = (i == rdy_dly);
                #1;
            end
            if (mem_req_valid) obs_req_cycles++;
            if (if_req_ready || ls_req_ready) obs_ready_busy = 1'b1;
            if ({mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask} !==
                {obs_wen, obs_addr, obs_wdata, obs_wmask}) obs_stable = 1'b0;
        end
        @(negedge clk);
        mem_req_ready = 1'b0;
        obs_resp_mrv = 1'b0; pulse_lat = -1; pulse_if = 1'b0; pulse_ls = 1'b0;
        pulse_err = 1'bx; pulse_data = 'x;
        for (int i = 0; i < WATCH; i++) begin
            mem_rsp_valid = send_rsp && (i == rsp_dly);
            mem_rsp_data  = (i == rsp_dly) ? data : {$urandom, $urandom};
            #1;
            if (mem_req_valid) obs_resp_mrv = 1'b1;
            if (if_rsp_valid || ls_rsp_valid) begin
                pulse_lat = cyc - t0; pulse_if = if_rsp_valid; pulse_ls = ls_rsp_valid;
                pulse_err = if_rsp_valid ? if_rsp_err : ls_rsp_err;
                pulse_data = if_rsp_valid ? if_rsp_data : ls_rsp_data;
                break;
            end
            if (if_req_ready || ls_req_ready) obs_ready_busy = 1'b1;
            @(negedge clk);
        end
        mem_rsp_valid = 1'b0;
        $display("txn acc_if=%0b acc_ls=%0b wen=%0b addr=%h lat=%0d rsp_if=%0b rsp_ls=%0b err=%0b data=%h",
                 acc_if, acc_ls, obs_wen, obs_addr, pulse_lat, pulse_if, pulse_ls, pulse_err, pulse_data);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        if_req_valid = 1'b0; if_req_addr = 64'h0;
        ls_req_valid = 1'b0; ls_req_wen = 1'b0; ls_req_addr = 64'h0; ls_req_wdata = 64'h0; ls_req_wmask = 8'h0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 64'h0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({busy, if_req_ready, ls_req_ready, mem_req_valid, if_rsp_valid, ls_rsp_valid, if_rsp_err, ls_rsp_err} !== 8'h0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000000",
                     {busy, if_req_ready, ls_req_ready, mem_req_valid, if_rsp_valid, ls_rsp_valid, if_rsp_err, ls_rsp_err});
        end
        checks++;
        if ({if_rsp_data, ls_rsp_data} !== 128'h0) begin
            failures++; $display("FAIL reset_rsp_data got=%h/%h exp=0", if_rsp_data, ls_rsp_data);
        end
        checks++;
        if ({mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask} !== 137'h0) begin
            failures++; $display("FAIL reset_mem_fields got=%b/%h/%h/%h exp=0", mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask);
        end
        @(negedge clk);
        rst = 1'b1;
        model_last_ls = 1'b0;
    endtask

    task automatic test_if_read();
        @(negedge clk);
        if_req_valid = 1'b1; if_req_addr = 64'h80000000;
        serve(0, 0, 1'b1, 64'h0000001300100093);
        checks++;
        if ({acc_if, acc_ls} !== 2'b10) begin failures++; $display("FAIL if_read_grant got=%b exp=10", {acc_if, acc_ls}); end
        checks++;
        if ({obs_wen, obs_addr, obs_wmask} !== {1'b0, 64'h80000000, 8'h0}) begin
            failures++; $display("FAIL if_read_fields got=%b/%h/%h exp=0/80000000/00", obs_wen, obs_addr, obs_wmask);
        end
        checks++;
        if ({obs_idle_mrv, obs_busy_req, obs_resp_mrv} !== 3'b010) begin
            failures++; $display("FAIL if_read_mrv_busy got=%b exp=010", {obs_idle_mrv, obs_busy_req, obs_resp_mrv});
        end
        checks++;
        if (pulse_lat !== 3) begin failures++; $display("FAIL if_read_latency got=%0d exp=3", pulse_lat); end
        checks++;
        if ({pulse_if, pulse_ls, pulse_err, pulse_data} !== {3'b100, 64'h0000001300100093}) begin
            failures++; $display("FAIL if_read_rsp got=%b%b%b/%h exp=100/0000001300100093", pulse_if, pulse_ls, pulse_err, pulse_data);
        end
        model_last_ls = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({if_rsp_valid, busy, if_rsp_data} !== {2'b00, 64'h0000001300100093}) begin
            failures++; $display("FAIL if_read_pulse_hold got=%b%b/%h exp=00/0000001300100093", if_rsp_valid, busy, if_rsp_data);
        end
    endtask

    task automatic test_priority();
        logic [63:0] d1, d2;
        d1 = {$urandom, $urandom}; d2 = {$urandom, $urandom};
        if_req_valid = 1'b1; if_req_addr = 64'h80000008;
        ls_req_valid = 1'b1; ls_req_wen = 1'b0; ls_req_addr = 64'h80002000; ls_req_wdata = 64'h0; ls_req_wmask = 8'hFF;
        serve(0, 1, 1'b1, d1);
        checks++;
        if ({acc_if, acc_ls, pulse_ls, pulse_data} !== {3'b011, d1}) begin
            failures++; $display("FAIL prio_ls_first got=%b%b%b/%h exp=011/%h", acc_if, acc_ls, pulse_ls, pulse_data, d1);
        end
        checks++;
        if (obs_addr !== 64'h80002000) begin failures++; $display("FAIL prio_ls_addr got=%h exp=80002000", obs_addr); end
        model_last_ls = 1'b1;
        serve(1, 0, 1'b1, d2);
        checks++;
        if ({acc_if, acc_ls, pulse_if, pulse_ls, pulse_data} !== {4'b1010, d2}) begin
            failures++; $display("FAIL prio_if_second got=%b%b%b%b/%h exp=1010/%h", acc_if, acc_ls, pulse_if, pulse_ls, pulse_data, d2);
        end
        checks++;
        if ({obs_addr, obs_wen, obs_wmask, obs_ready_busy} !== {64'h80000008, 1'b0, 8'h0, 1'b0}) begin
            failures++; $display("FAIL prio_if_fields got=%h/%b/%h/%b exp=80000008/0/00/0", obs_addr, obs_wen, obs_wmask, obs_ready_busy);
        end
        model_last_ls = 1'b0;
    endtask

    task automatic test_write_stall();
        ls_req_valid = 1'b1; ls_req_wen = 1'b1; ls_req_addr = 64'h80001000;
        ls_req_wdata = 64'hDEADBEEF; ls_req_wmask = 8'h0F;
        serve(3, 2, 1'b1, 64'hCAFEF00D12345678);
        checks++;
        if ({obs_wen, obs_addr, obs_wdata, obs_wmask} !== {1'b1, 64'h80001000, 64'hDEADBEEF, 8'h0F}) begin
            failures++; $display("FAIL wr_fields got=%b/%h/%h/%h exp=1/80001000/deadbeef/0f", obs_wen, obs_addr, obs_wdata, obs_wmask);
        end
        checks++;
        if ({obs_req_cycles, obs_stable} !== {32'd4, 1'b1}) begin
            failures++; $display("FAIL wr_stall got_cycles=%0d stable=%0b exp=4/1", obs_req_cycles, obs_stable);
        end
        checks++;
        if ({pulse_ls, pulse_err, pulse_data, pulse_lat} !== {2'b10, 64'h0, 32'd8}) begin
            failures++; $display("FAIL wr_rsp got=%b%b/%h lat=%0d exp=10/0 lat=8", pulse_ls, pulse_err, pulse_data, pulse_lat);
        end
        model_last_ls = 1'b1;
    endtask

    task automatic test_timeout();
        logic [63:0] d;
        ls_req_valid = 1'b1; ls_req_wen = 1'b0; ls_req_addr = rand_addr();
        serve(0, 0, 1'b0, 64'h0);
        checks++;
        if ({pulse_ls, pulse_err, pulse_data, pulse_lat} !== {2'b11, 64'h0, 32'(2 + TMO)}) begin
            failures++; $display("FAIL tmo_rsp got=%b%b/%h lat=%0d exp=11/0 lat=%0d", pulse_ls, pulse_err, pulse_data, pulse_lat, 2 + TMO);
        end
        @(negedge clk);
        mem_rsp_valid = 1'b1; mem_rsp_data = {$urandom, $urandom};
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL tmo_idle_busy got=%b exp=0", busy); end
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        #1;
        checks++;
        if ({if_rsp_valid, ls_rsp_valid, busy, ls_rsp_err} !== 4'b0001) begin
            failures++; $display("FAIL tmo_late_ignored got=%b exp=0001", {if_rsp_valid, ls_rsp_valid, busy, ls_rsp_err});
        end
        d = {$urandom, $urandom};
        ls_req_valid = 1'b1; ls_req_wen = 1'b0; ls_req_addr = rand_addr();
        serve(0, TMO - 1, 1'b1, d);
        checks++;
        if ({pulse_ls, pulse_err, pulse_data, pulse_lat} !== {2'b10, d, 32'(2 + TMO)}) begin
            failures++; $display("FAIL tmo_edge_data got=%b%b/%h lat=%0d exp=10/%h lat=%0d", pulse_ls, pulse_err, pulse_data, pulse_lat, d, 2 + TMO);
        end
        ls_req_valid = 1'b1; ls_req_wen = 1'b0; ls_req_addr = rand_addr();
        serve(1, TMO, 1'b1, d);
        checks++;
        if ({pulse_ls, pulse_err, pulse_data, pulse_lat} !== {2'b11, 64'h0, 32'(3 + TMO)}) begin
            failures++; $display("FAIL tmo_one_late got=%b%b/%h lat=%0d exp=11/0 lat=%0d", pulse_ls, pulse_err, pulse_data, pulse_lat, 3 + TMO);
        end
        model_last_ls = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit seen;
        logic [63:0] d;
        @(negedge clk);
        if_req_valid = 1'b1; if_req_addr = rand_addr();
        #1;
        checks++;
        if (if_req_ready !== 1'b1) begin failures++; $display("FAIL rmid_accept got=%b exp=1", if_req_ready); end
        @(negedge clk);
        if_req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0; rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL rmid_in_resp got=%b exp=1", busy); end
        @(negedge clk);
        rst = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = {$urandom, $urandom};
        #1;
        checks++;
        if ({busy, mem_req_valid, if_rsp_err, ls_rsp_err, if_rsp_data, ls_rsp_data} !== 132'h0) begin
            failures++; $display("FAIL rmid_cleared got=%b%b%b%b/%h/%h exp=0", busy, mem_req_valid, if_rsp_err, ls_rsp_err, if_rsp_data, ls_rsp_data);
        end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            #1;
            if (if_rsp_valid || ls_rsp_valid || busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL rmid_stale_pulse got=1 exp=0"); end
        model_last_ls = 1'b0;
        d = {$urandom, $urandom};
        if_req_valid = 1'b1; if_req_addr = 64'h80000040;
        serve(0, 0, 1'b1, d);
        checks++;
        if ({acc_if, pulse_if, pulse_err, pulse_data, pulse_lat} !== {3'b110, d, 32'd3}) begin
            failures++; $display("FAIL rmid_after got=%b%b%b/%h lat=%0d exp=110/%h lat=3", acc_if, pulse_if, pulse_err, pulse_data, pulse_lat, d);
        end
        model_last_ls = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit exp_ls, exp_err;
        int rdy, dly, exp_lat;
        logic [63:0] d, exp_data;
        if_req_valid = 1'b1; if_req_addr = rand_addr();
        ls_req_valid = 1'b1; ls_req_wen = 1'b0; ls_req_addr = rand_addr();
        for (int k = 0; k < 6; k++) begin
            exp_ls = model_pick_ls(if_req_valid, ls_req_valid, model_last_ls);
            rdy = int'($urandom_range(0, 1)); dly = int'($urandom_range(0, 2)); d = {$urandom, $urandom};
            model_resp(rdy, dly, 1'b1, 1'b0, d, exp_lat, exp_err, exp_data);
            serve(rdy, dly, 1'b1, d);
            checks++;
            if ({acc_if, acc_ls, pulse_if, pulse_ls} !== {!exp_ls, exp_ls, !exp_ls, exp_ls}) begin
                failures++; $display("FAIL b2b_grant k=%0d got=%b%b%b%b exp_ls=%0b", k, acc_if, acc_ls, pulse_if, pulse_ls, exp_ls);
            end
            checks++;
            if ({pulse_err, pulse_data, pulse_lat, obs_ready_busy} !== {exp_err, exp_data, exp_lat, 1'b0}) begin
                failures++; $display("FAIL b2b_rsp k=%0d got=%b/%h lat=%0d rb=%0b exp=%b/%h lat=%0d", k, pulse_err, pulse_data, pulse_lat, obs_ready_busy, exp_err, exp_data, exp_lat);
            end
            model_last_ls = exp_ls;
            if (exp_ls) begin ls_req_valid = 1'b1; ls_req_wen = 1'b0; ls_req_addr = rand_addr(); end
            else begin if_req_valid = 1'b1; if_req_addr = rand_addr(); end
        end
    endtask

    task automatic test_random();
        bit exp_ls, exp_err, e_wen;
        int rdy, dly, exp_lat;
        logic [63:0] d, exp_data, e_addr, e_wdata;
        logic [7:0] e_wmask;
        for (int k = 0; k < 30; k++) begin
            if (!if_req_valid && $urandom_range(0, 1) == 1) begin if_req_valid = 1'b1; if_req_addr = rand_addr(); end
            if (!ls_req_valid && ($urandom_range(0, 1) == 1 || !if_req_valid)) begin
                ls_req_valid = 1'b1; ls_req_wen = 1'($urandom); ls_req_addr = rand_addr();
                ls_req_wdata = {$urandom, $urandom}; ls_req_wmask = 8'($urandom);
            end
            exp_ls = model_pick_ls(if_req_valid, ls_req_valid, model_last_ls);
            e_wen = exp_ls ? ls_req_wen : 1'b0;
            e_addr = exp_ls ? ls_req_addr : if_req_addr;
            e_wdata = ls_req_wdata;
            e_wmask = exp_ls ? ls_req_wmask : 8'h0;
            rdy = int'($urandom_range(0, 2));
            case ($urandom_range(0, 7))
                0: dly = TMO + int'($urandom_range(0, 2));
                1: dly = TMO - 1;
                default: dly = int'($urandom_range(0, 3));
            endcase
            d = {$urandom, $urandom};
            model_resp(rdy, dly, 1'b1, e_wen, d, exp_lat, exp_err, exp_data);
            serve(rdy, dly, 1'b1, d);
            checks++;
            if ({acc_if, acc_ls, pulse_if, pulse_ls} !== {!exp_ls, exp_ls, !exp_ls, exp_ls}) begin
                failures++; $display("FAIL rnd_grant k=%0d got=%b%b%b%b exp_ls=%0b", k, acc_if, acc_ls, pulse_if, pulse_ls, exp_ls);
            end
            checks++;
            if ({obs_wen, obs_addr, obs_wmask, obs_stable} !== {e_wen, e_addr, e_wmask, 1'b1} ||
                (exp_ls && obs_wdata !== e_wdata)) begin
                failures++; $display("FAIL rnd_fields k=%0d got=%b/%h/%h/%h st=%0b exp=%b/%h/%h/%h", k, obs_wen, obs_addr, obs_wdata, obs_wmask, obs_stable, e_wen, e_addr, e_wdata, e_wmask);
            end
            checks++;
            if ({pulse_err, pulse_data, pulse_lat, obs_req_cycles} !== {exp_err, exp_data, exp_lat, rdy + 1}) begin
                failures++; $display("FAIL rnd_rsp k=%0d got=%b/%h lat=%0d req=%0d exp=%b/%h lat=%0d req=%0d", k, pulse_err, pulse_data, pulse_lat, obs_req_cycles, exp_err, exp_data, exp_lat, rdy + 1);
            end
            checks++;
            if ({obs_idle_mrv, obs_resp_mrv, obs_ready_busy} !== 3'b000) begin
                failures++; $display("FAIL rnd_ctrl k=%0d got=%b exp=000", k, {obs_idle_mrv, obs_resp_mrv, obs_ready_busy});
            end
            model_last_ls = exp_ls;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_if_read();
        test_priority();
        test_write_stall();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ysyx_22040088_memarb.md
YSYX_22040088_MEMARB -- requirements
Module: ysyx_22040088_memarb

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the max RESP-state cycles waited for mem_rsp_valid (legal 2..255).
REQ-002 clk  in  1  sole clock; all state SHALL update on rising edge.
REQ-003 rst  in  1  synchronous, active-low reset; sampled on rising clk.
REQ-004 if_req_valid  in  1  fetch read request.
REQ-005 if_req_addr  in  64  fetch address, 8-byte aligned.
REQ-006 if_req_ready  out  1  fetch request accepted this cycle.
REQ-007 if_rsp_valid / if_rsp_err / if_rsp_data  out  1/1/64  fetch response pulse, error flag, read data.
REQ-008 ls_req_valid / ls_req_wen  in  1/1  load-store request; wen=1 write.
REQ-009 ls_req_addr / ls_req_wdata / ls_req_wmask  in  64/64/8  address, write data, byte strobes.
REQ-010 ls_req_ready  out  1  load-store request accepted this cycle.
REQ-011 ls_rsp_valid / ls_rsp_err / ls_rsp_data  out  1/1/64  load-store response pulse, error flag, read data.
REQ-012 mem_req_valid / mem_req_wen  out  1/1  downstream request, write enable.
REQ-013 mem_req_addr / mem_req_wdata / mem_req_wmask  out  64/64/8  downstream request fields.
REQ-014 mem_req_ready  in  1  downstream accepts request.
REQ-015 mem_rsp_valid / mem_rsp_data  in  1/64  downstream response (reads and write acks).
REQ-016 busy  out  1  high whenever state != IDLE.

Function
REQ-017 FSM states SHALL be IDLE, REQ, RESP; one transaction outstanding at most.
REQ-018 IDLE: grant SHALL be computed combinationally; exactly one of if_req_ready/ls_req_ready high only when its valid is high and it is granted.
REQ-019 Priority: LS over IF, except when both valid and last_grant==LS, then IF wins; last_grant updates on each accept.
REQ-020 On accept (valid&ready): owner, wen, addr, wdata, wmask SHALL be registered (IF: wen=0, wmask=0); next state REQ.
REQ-021 REQ: mem_req_valid=1, fields from registers, held stable until mem_req_ready; on mem_req_ready -> RESP, timeout counter cleared.
REQ-022 RESP: on mem_rsp_valid, owner's rsp_valid SHALL pulse exactly one cycle in the next cycle, rsp_data=registered mem_rsp_data (0 for writes), rsp_err=0; state -> IDLE.
REQ-023 RESP: counter increments each cycle without mem_rsp_valid; on reaching TIMEOUT, owner rsp_valid pulses with rsp_err=1, rsp_data=0; state -> IDLE.
REQ-024 mem_rsp_valid outside RESP SHALL be ignored (no response pulse, no state change).
REQ-025 mem_rsp_valid in same cycle counter hits TIMEOUT: data response wins, err=0.
REQ-026 Non-owner rsp_valid SHALL stay 0; rsp_data/err hold last value between pulses.
REQ-027 Latency: accept cycle N, mem_req_ready at N+1, mem_rsp_valid at N+2 -> rsp_valid at N+3; IDLE at N+3, so new accept possible at N+3.
REQ-028 Both ready signals SHALL be 0 outside IDLE; requesters hold valid and fields until ready.
REQ-029 mem_req_valid SHALL be 0 in IDLE and RESP.

Reset
REQ-030 rst=0 at a rising edge SHALL force IDLE, last_grant=IF, counter=0, all valid/ready/err/busy outputs 0, rsp_data and mem_req_* fields 0.
REQ-031 Reset mid-transaction SHALL drop it with no response pulse; a later stale mem_rsp_valid SHALL be ignored.

Verification
REQ-032 IF read 0x80000000, mem_req_ready=1 next cycle, rsp 0x00000013_00100093 next -> if_rsp_valid 1 cycle at N+3, data 0x0000001300100093, err 0.
REQ-033 IF and LS valid same cycle, last_grant=IF -> LS granted; both held -> IF granted next, ls_rsp precedes if_rsp.
REQ-034 LS write addr 0x80001000 wdata 0xDEADBEEF wmask 0x0F, mem_req_ready low 3 cycles -> mem_req fields stable 4 cycles, ls_rsp_valid err 0 data 0.
REQ-035 TIMEOUT=16, no mem_rsp_valid -> ls_rsp_valid err=1 data 0 exactly 16 cycles after RESP entry; late mem_rsp_valid ignored.
REQ-036 rst=0 while in RESP, then mem_rsp_valid -> no rsp pulse, busy=0, next IF request served normally.
REQ-037 Back-to-back LS loads with IF valid continuously -> grants alternate LS, IF, LS; no starvation.
